arbitro_rr: RTL and testbench
=============================

# arbitro_rr

Round-robin arbiter/scheduler between four input FIFOs (P0–P3) and four output FIFOs. It pops one word per cycle from the granted input FIFO and routes it to the output FIFO selected by the word's destination field. It limits each grant to a burst quantum and respects output `almost_full` backpressure. It sits between the input FIFO bank and the output FIFO bank, replacing fixed-priority selection with fair sharing.

## Interface
- `WIDTH`, default 12, word width; destination = `word[WIDTH-1:WIDTH-2]`
- `BURST`, default 4, maximum words popped per grant (≥1)
- `BLOCK_MAX`, default 2, consecutive blocked cycles before grant is released (≥1)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `data_in`  in  4*WIDTH  head words of input FIFOs; port i at `[i*WIDTH +: WIDTH]`, valid when `empty[i]`=0 (show-ahead FIFOs)
- `empty`  in  4  input FIFO empty flags
- `almost_full`  in  4  output FIFO almost-full flags
- `pop`  out  4  one-hot (or zero) pop to input FIFOs, combinational from registered state and inputs
- `push`  out  4  one-hot (or zero) push to output FIFOs, registered
- `data_out`  out  WIDTH  word written with `push`, registered
- `grant`  out  2  currently/last granted port, registered
- `idle`  out  1  high when FSM in IDLE

## Operation
- States: IDLE, SERVE. Registers: `ptr`[1:0], `grant`, `burst_cnt`, `blk_cnt`.
- IDLE: select first port i scanning `ptr`, `ptr+1`, … (mod 4) with `empty[i]`=0; next edge → SERVE, `grant`=i, `burst_cnt`=0, `blk_cnt`=0. If none, stay IDLE.
- SERVE, with g=`grant` and d=dest(`data_in[g]`):
  - `pop[g]`=1 iff `empty[g]`=0 and `almost_full[d]`=0; all other `pop` bits 0.
  - On a pop edge: `push` ← onehot(d), `data_out` ← `data_in[g]`, `burst_cnt`++, `blk_cnt`=0. If `burst_cnt` was BURST-1 → IDLE, `ptr`=g+1.
  - Cycles without a pop: `push` ← 0 and `data_out` holds.
  - If `empty[g]`=1: no pop; → IDLE, `ptr`=g+1.
  - If blocked (`empty[g]`=0, `almost_full[d]`=1): no pop, `blk_cnt`++. If `blk_cnt` reaches BLOCK_MAX → IDLE, `ptr`=g+1.
- In IDLE, `pop`=0.
- `ptr` wraps 3→0. `almost_full` on one output never blocks ports whose head targets another output.
- `almost_full` must assert with ≥1 free entry, which absorbs the one in-flight word.

## Timing
- Reset values: `pop`=0, `push`=0, `data_out`=0, `grant`=0, `idle`=1, `ptr`=0, counters 0.
- Request to first pop: `empty[i]` falls before edge k → SERVE at k → `pop` high in cycle k..k+1.
- Pop to push latency: exactly 1 cycle. `push` and `data_out` update on the same edge that consumes the pop.
- Sustained throughput: 1 word/cycle within a grant. Each grant switch costs 1 IDLE bubble cycle.
- `empty[g]` or `almost_full[d]` changing mid-cycle affects `pop` combinationally in that same cycle.
- `reset` mid-burst: `push` and `pop` drop asynchronously and the FSM returns to IDLE with `ptr`=0. An in-flight word is discarded.

## Configuration
- `ARB_STATS_EN` defined: adds output `word_cnt` [4*16], with one 16-bit saturating counter per input port of words popped, cleared by `reset`.
- `ARB_STATS_EN` undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Package `arbitro_pkg`: state encoding (IDLE=0, SERVE=1), `NPORTS`=4, destination-field MSB/LSB constants, `onehot4` function.
- Sub-module `rr_select`: combinational; inputs `ptr` and request vector (~`empty`), outputs `found` and port index. Used only in IDLE.

## Test plan
- Reset, all `empty`=4'b1111 → `idle`=1, `pop`=`push`=0 indefinitely.
- Only P0 non-empty with 6 words of 12'b001010010110 → 4 pops (BURST), 1 IDLE cycle, then 2 pops. Each pop is followed one cycle later by `push`=4'b0001 and `data_out`=12'b001010010110.
- P0 and P2 non-empty continuously, `ptr`=0 → grants alternate P0 (4 words), P2 (4 words), P0 …; `grant` sequence 0,2,0.
- P1 head 12'b101011110000 (dest 2) with `almost_full[2]`=1 and P3 head dest 0 → P1 is blocked for 2 cycles, grant releases, P3 served with `push`=4'b0001. P1 resumes after `almost_full[2]` falls.
- `empty[g]` rises after 2 words of a burst → no pop that cycle, FSM goes to IDLE next edge, `ptr`=g+1.
- `reset` asserted mid-burst → `push`=0 and `pop`=0 immediately, `idle`=1. After release, arbitration restarts from P0.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared types and constants for the arbitro_rr round-robin FIFO arbiter.
package arbitro_pkg;

    localparam int NPORTS = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // Destination field sits in the top two bits: MSB = WIDTH-DEST_MSB_OFS, LSB = WIDTH-DEST_LSB_OFS
    localparam int DEST_MSB_OFS = 1;
    localparam int DEST_LSB_OFS = 2;

    function automatic logic [NPORTS-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arbitro_rr_select.sv
// Round-robin scan: picks the first requesting port starting at i_ptr, wrapping mod 4.
module rr_select
    import arbitro_pkg::*;
(
    input  logic [1:0]        i_ptr,
    input  logic [NPORTS-1:0] i_req,
    output logic              o_found,
    output logic [1:0]        o_idx
);

    always_comb begin
        logic [1:0] w_cand;
        o_found = 1'b0;
        o_idx   = i_ptr;
        w_cand  = i_ptr;
        // Walk offsets from farthest to nearest so the nearest requester wins
        for (int k = NPORTS - 1; k >= 0; k--) begin
            w_cand = i_ptr + 2'(k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter between four input FIFOs and four output FIFOs with burst quantum
// and almost_full backpressure. Define ARB_STATS_EN to add per-port popped-word counters.
module arbitro_rr
    import arbitro_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int BURST     = 4,
    parameter int BLOCK_MAX = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NPORTS*WIDTH-1:0] data_in,
    input  logic [NPORTS-1:0]       empty,
    input  logic [NPORTS-1:0]       almost_full,
    output logic [NPORTS-1:0]       pop,
    output logic [NPORTS-1:0]       push,
    output logic [WIDTH-1:0]        data_out,
    output logic [1:0]              grant,
    output logic                    idle
`ifdef ARB_STATS_EN
    ,
    output logic [NPORTS*16-1:0]    word_cnt
`endif
);

    localparam int BCW = $clog2(BURST + 1);
    localparam int KCW = $clog2(BLOCK_MAX + 1);

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_grant;
    logic [BCW-1:0]   r_burst_cnt;
    logic [KCW-1:0]   r_blk_cnt;
    logic [NPORTS-1:0] r_push;
    logic [WIDTH-1:0] r_data_out;

    logic             w_found;
    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_head;
    logic [1:0]       w_dest;
    logic             w_pop_ok;

    rr_select u_sel (
        .i_ptr   (r_ptr),
        .i_req   (~empty),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    always_comb begin
        w_head = data_in[WIDTH-1:0];
        for (int i = 0; i < NPORTS; i++) begin
            if (r_grant == 2'(i)) w_head = data_in[i*WIDTH +: WIDTH];
        end
    end

    assign w_dest   = w_head[WIDTH-DEST_MSB_OFS -: 2];
    assign w_pop_ok = (r_state == ST_SERVE) && !empty[r_grant] && !almost_full[w_dest];

    assign pop      = w_pop_ok ? onehot4(r_grant) : '0;
    assign push     = r_push;
    assign data_out = r_data_out;
    assign grant    = r_grant;
    assign idle     = (r_state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_burst_cnt <= '0;
            r_blk_cnt   <= '0;
            r_push      <= '0;
            r_data_out  <= '0;
        end else begin
            r_push <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state     <= ST_SERVE;
                        r_grant     <= w_sel;
                        r_burst_cnt <= '0;
                        r_blk_cnt   <= '0;
                    end
                end
                ST_SERVE: begin
                    if (w_pop_ok) begin
                        r_push      <= onehot4(w_dest);
                        r_data_out  <= w_head;
                        r_blk_cnt   <= '0;
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (r_burst_cnt == BCW'(BURST - 1)) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= r_grant + 2'd1;
                        end
                    end else if (empty[r_grant]) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_grant + 2'd1;
                    end else begin
                        // Head is blocked by its output; give up the grant after BLOCK_MAX tries
                        r_blk_cnt <= r_blk_cnt + 1'b1;
                        if (r_blk_cnt == KCW'(BLOCK_MAX - 1)) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= r_grant + 2'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    for (genvar p = 0; p < NPORTS; p++) begin : g_stats
        logic [15:0] r_cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (pop[p] && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign word_cnt[p*16 +: 16] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: modelled input FIFOs feed the DUT, a queue of expected pushes is checked.
module tb_arbitro_rr;

    typedef logic [11:0] word_t;
    typedef struct {
        logic [3:0] push;
        word_t      data;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] data_in;
    logic [3:0]  empty;
    logic [3:0]  af;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [11:0] data_out;
    logic [1:0]  grant;
    logic        idle;
`ifdef ARB_STATS_EN
    logic [63:0] word_cnt;
`endif

    word_t fq [4][$];
    sb_t   sb [$];
    word_t last_data;
    int    n_chk = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    arbitro_rr dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .empty       (empty),
        .almost_full (af),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .grant       (grant),
        .idle        (idle)
`ifdef ARB_STATS_EN
        ,
        .word_cnt    (word_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            empty[i] = (fq[i].size() == 0);
            data_in[i*12 +: 12] = (fq[i].size() > 0) ? fq[i][0] : 12'h000;
        end
    endtask

    // One clock cycle: check pop against exp_pop, queue expected push, then check registered outputs.
    task automatic cyc(input logic [3:0] exp_pop, input string tag);
        logic [3:0] p;
        sb_t        e;
        drive();
        #1;
        p = pop;
        chk({tag, "/pop"}, 32'(p), 32'(exp_pop));
        for (int i = 0; i < 4; i++) begin
            if (exp_pop[i] && fq[i].size() > 0) begin
                e.push = 4'b0001 << fq[i][0][11:10];
                e.data = fq[i][0];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "/push"}, 32'(push), 32'(e.push));
            chk({tag, "/data"}, 32'(data_out), 32'(e.data));
            last_data = e.data;
        end else begin
            chk({tag, "/push0"}, 32'(push), 32'h0);
            chk({tag, "/hold"}, 32'(data_out), 32'(last_data));
        end
    endtask

    // Reset from a point just after a rising edge; clears model state too.
    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 4; i++) fq[i].delete();
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_data = '0;
    endtask

    initial begin
        reset = 1'b1;
        af = 4'b0000;
        last_data = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state with all inputs empty
        chk("rst/idle", 32'(idle), 32'h1);
        chk("rst/grant", 32'(grant), 32'h0);
        chk("rst/data", 32'(data_out), 32'h0);
        for (int k = 0; k < 3; k++) cyc(4'b0000, "empty");
        chk("empty/idle", 32'(idle), 32'h1);

        // P0 alone with 6 words: burst of 4, bubble, then 2
        for (int k = 0; k < 6; k++) fq[0].push_back(12'b001010010110);
        cyc(4'b0000, "p0c0");
        chk("p0/serve", 32'(idle), 32'h0);
        for (int k = 0; k < 4; k++) cyc(4'b0001, "p0burst");
        chk("p0/release", 32'(idle), 32'h1);
        cyc(4'b0000, "p0bubble");
        cyc(4'b0001, "p0tail");
        cyc(4'b0001, "p0tail");
        cyc(4'b0000, "p0drained");
        cyc(4'b0000, "p0idle");
        chk("p0/grant", 32'(grant), 32'h0);

        // P0 and P2 both busy from ptr=0: grant order 0,2,0
        do_reset();
        for (int k = 0; k < 9; k++) begin
            fq[0].push_back(12'h400 + 12'(k));
            fq[2].push_back(12'hC10 + 12'(k));
        end
        cyc(4'b0000, "alt0");
        chk("alt/g0", 32'(grant), 32'h0);
        for (int k = 0; k < 4; k++) cyc(4'b0001, "altP0");
        cyc(4'b0000, "altbub1");
        chk("alt/g2", 32'(grant), 32'h2);
        for (int k = 0; k < 4; k++) cyc(4'b0100, "altP2");
        cyc(4'b0000, "altbub2");
        chk("alt/g0b", 32'(grant), 32'h0);
        for (int k = 0; k < 4; k++) cyc(4'b0001, "altP0b");

        // P1 blocked by almost_full[2]; P3 (dest 0) still served
        do_reset();
        af = 4'b0100;
        fq[1].push_back(12'b101011110000);
        fq[1].push_back(12'hAF1);
        fq[3].push_back(12'h033);
        fq[3].push_back(12'h034);
        cyc(4'b0000, "blk_idle");
        chk("blk/g1", 32'(grant), 32'h1);
        cyc(4'b0000, "blk1");
        cyc(4'b0000, "blk2");
        chk("blk/released", 32'(idle), 32'h1);
        cyc(4'b0000, "blk_rr");
        chk("blk/g3", 32'(grant), 32'h3);
        cyc(4'b1000, "p3pop");
        cyc(4'b1000, "p3pop");
        cyc(4'b0000, "p3empty");
        af = 4'b0000;
        cyc(4'b0000, "p1regrant");
        cyc(4'b0010, "p1resume");
        cyc(4'b0010, "p1resume");
        cyc(4'b0000, "p1empty");

        // P2 runs dry after 2 words; ptr must advance to 3
        do_reset();
        fq[2].push_back(12'h5A1);
        fq[2].push_back(12'h5A2);
        cyc(4'b0000, "dry_idle");
        cyc(4'b0100, "dry");
        cyc(4'b0100, "dry");
        cyc(4'b0000, "dry_empty");
        chk("dry/idle", 32'(idle), 32'h1);
        fq[0].push_back(12'h111);
        fq[3].push_back(12'hE22);
        cyc(4'b0000, "ptr3");
        chk("dry/ptr3", 32'(grant), 32'h3);
        cyc(4'b1000, "p3one");
        cyc(4'b0000, "p3dry");
        cyc(4'b0000, "p0sel");
        cyc(4'b0001, "p0one");
        cyc(4'b0000, "end5");

        // Reset mid-burst drops pop/push at once, then restart from P0
        do_reset();
        for (int k = 0; k < 6; k++) fq[1].push_back(12'h7B0 + 12'(k));
        cyc(4'b0000, "mid_idle");
        cyc(4'b0010, "mid");
        cyc(4'b0010, "mid");
        drive();
        #1;
        chk("mid/pop_before", 32'(pop), 32'h2);
        chk("mid/push_before", 32'(push), 32'h2);
        reset = 1'b1;
        #1;
        chk("mid/pop_rst", 32'(pop), 32'h0);
        chk("mid/push_rst", 32'(push), 32'h0);
        chk("mid/idle_rst", 32'(idle), 32'h1);
        chk("mid/data_rst", 32'(data_out), 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_data = '0;
        fq[0].push_back(12'h321);
        cyc(4'b0000, "post_idle");
        chk("post/g0", 32'(grant), 32'h0);
        cyc(4'b0001, "post_p0");
        cyc(4'b0000, "post_p0dry");
        cyc(4'b0000, "post_rr");
        chk("post/g1", 32'(grant), 32'h1);
        cyc(4'b0010, "post_p1");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
